poly_small_mkgauss_mc: RTL

Parametrised successor to the Falcon small-polynomial Gaussian sampler in the keygen path. On one start pulse it streams NPOLY polynomials (for example f then g) of n = 2^LOGN signed coefficients each. Each coefficient is the sum of 2^(10-LOGN) CDT samples from the gauss_1024_12289 distribution, one 128-bit RNG word per sample. The block adds output back-pressure, configurable coefficient width with range rejection, and optional odd-parity enforcement per polynomial.

---
 rtl/poly_small_mkgauss_pkg.sv | 44 ++++
 rtl/poly_small_mkgauss_mc_sampler.sv | 39 +++
 rtl/poly_small_mkgauss_mc.sv | 130 +++++++++++++
 3 files changed

// File: rtl/poly_small_mkgauss_pkg.sv
// poly_small_mkgauss_pkg: gauss_1024_12289 CDT, FSM states and
// accumulator width shared by the small-polynomial sampler.
package poly_small_mkgauss_pkg;

  localparam int ACC_W = 16;
  localparam int CDT_N = 27;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    OUT
  } state_t;

  localparam logic [62:0] CDT [CDT_N] = '{
    63'd1283868770400643928,
    63'd6416574995475331444,
    63'd4078260278032692663,
    63'd2353523259288686585,
    63'd1227179971273316331,
    63'd575931623374121527,
    63'd242543240509105209,
    63'd91437049221049666,
    63'd30799446349977173,
    63'd9255276791179340,
    63'd2478152334826140,
    63'd590642893610164,
    63'd125206034929641,
    63'd23590435911403,
    63'd3948334035941,
    63'd586753615614,
    63'd77391054539,
    63'd9056793210,
    63'd940121950,
    63'd86539696,
    63'd7062824,
    63'd510971,
    63'd32764,
    63'd1862,
    63'd94,
    63'd4,
    63'd0
  };

endpackage

// File: rtl/poly_small_mkgauss_mc_sampler.sv
// gauss_cdt_sampler: one CDT draw per 128-bit word, combinational,
// producing a signed sample in -26..26.
module gauss_cdt_sampler
  import poly_small_mkgauss_pkg::*;
(
  input  logic [127:0]      rng,
  output logic signed [5:0] sample
);

  logic        neg;
  logic [62:0] r0;
  logic [62:0] r1;
  logic [26:1] ge;
  logic [4:0]  v;
  logic        unused_bit;

  assign neg        = rng[127];
  assign r0         = rng[126:64];
  assign r1         = rng[62:0];
  assign unused_bit = rng[63];

  always_comb begin
    ge = '0;
    for (int k = 1; k < CDT_N; k++)
      ge[k] = (r1 >= CDT[k]);
  end

  // Lowest matching k wins; r0 below CDT[0] forces zero.
  always_comb begin
    v = '0;
    for (int k = CDT_N - 1; k >= 1; k--)
      if (ge[k]) v = 5'(k);
    if (r0 < CDT[0]) v = '0;
  end

  assign sample = neg ? -$signed({1'b0, v})
                      :  $signed({1'b0, v});

endmodule

// File: rtl/poly_small_mkgauss_mc.sv
// poly_small_mkgauss_mc: streams NPOLY small Gaussian polynomials with
// range rejection; define MKGAUSS_PARITY_EN for odd per-poly sums.
module poly_small_mkgauss_mc
  import poly_small_mkgauss_pkg::*;
#(
  parameter int LOGN   = 9,
  parameter int NPOLY  = 2,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              rng_valid,
  input  logic [127:0]      rng,
  output logic              rng_extract,
  output logic              f_valid,
  input  logic              f_ready,
  output logic [COEF_W-1:0] f,
  output logic [LOGN-1:0]   f_idx,
  output logic [1:0]        f_poly,
  output logic              f_last,
  output logic              busy,
  output logic              done
);

  localparam int N = 1 << LOGN;
  localparam int G = 1 << (10 - LOGN);
  localparam logic signed [ACC_W-1:0] LIM =
    ACC_W'((1 << (COEF_W - 1)) - 1);
  localparam logic [10:0]     G_LAST    = 11'(G - 1);
  localparam logic [LOGN-1:0] IDX_LAST  = LOGN'(N - 1);
  localparam logic [1:0]      POLY_LAST = 2'(NPOLY - 1);

  state_t                  state;
  state_t                  state_nx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic [10:0]             draw_cnt;
  logic [LOGN-1:0]         idx;
  logic [1:0]              poly;
  logic signed [5:0]       sample;
  logic                    last_draw;
  logic                    in_range;
  logic                    par_ok;
  logic                    accept;
  logic                    hs;
  logic                    final_hs;

  gauss_cdt_sampler u_cdt (
    .rng    (rng),
    .sample (sample)
  );

  assign acc_sum   = acc + ACC_W'(sample);
  assign last_draw = draw_cnt == G_LAST;
  assign in_range  = (acc_sum <= LIM) && (acc_sum >= -LIM);

`ifdef MKGAUSS_PARITY_EN
  logic par;

  // XOR of emitted LSBs; the closing coefficient must make it odd.
  assign par_ok = (idx != IDX_LAST) || (par ^ acc_sum[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  par <= 1'b0;
    else if (hs) par <= f_last ? 1'b0 : (par ^ f[0]);
  end
`else
  assign par_ok = 1'b1;
`endif

  assign rng_extract = (state == DRAW) && rng_valid;
  assign accept   = rng_extract && last_draw && in_range && par_ok;
  assign hs       = (state == OUT) && f_ready;
  assign final_hs = hs && (idx == IDX_LAST) && (poly == POLY_LAST);

  assign f_valid = state == OUT;
  assign busy    = state != IDLE;
  assign f_idx   = idx;
  assign f_poly  = poly;
  assign f_last  = idx == IDX_LAST;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (ena) state_nx = DRAW;
      DRAW: if (accept) state_nx = OUT;
      OUT: begin
        if (final_hs)  state_nx = IDLE;
        else if (hs)   state_nx = DRAW;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      draw_cnt <= '0;
      idx      <= '0;
      poly     <= '0;
      f        <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= final_hs;
      // A finished attempt always restarts from zero, accepted or not.
      if (rng_extract) begin
        if (last_draw) begin
          acc      <= '0;
          draw_cnt <= '0;
        end else begin
          acc      <= acc_sum;
          draw_cnt <= draw_cnt + 11'd1;
        end
      end
      if (accept) f <= acc_sum[COEF_W-1:0];
      if (hs) begin
        if (f_last) begin
          idx  <= '0;
          poly <= final_hs ? 2'd0 : poly + 2'd1;
        end else begin
          idx  <= idx + LOGN'(1);
        end
      end
    end
  end

endmodule
